sram_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one SRAM instance (separate raddr/waddr ports, registered dout)

---
 rtl/sram_rr_arbiter_if.sv | 39 +++
 rtl/sram_rr_arbiter.sv | 118 +++++++++++
 tb/tb_sram_rr_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_rr_arbiter_if.sv
// Requester/SRAM-side bundle for sram_rr_arbiter: request handshake, read response and SRAM pins.
// The arbiter connects through the slave modport; the environment (requesters + SRAM) uses master.
interface sram_rr_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDW        = 1
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_wr;
  logic [NREQ-1:0]            req_lock;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]            req_ready;

  logic                       rsp_valid;
  logic [IDW-1:0]             rsp_id;
  logic [DATA_WIDTH-1:0]      rsp_data;

  logic                       sram_chip_en;
  logic                       sram_wen;
  logic                       sram_ren;
  logic [ADDR_WIDTH-1:0]      sram_waddr;
  logic [ADDR_WIDTH-1:0]      sram_raddr;
  logic [DATA_WIDTH-1:0]      sram_din;
  logic [DATA_WIDTH-1:0]      sram_dout;

  modport slave (
    input  req_valid, req_wr, req_lock, req_addr, req_wdata, sram_dout,
    output req_ready, rsp_valid, rsp_id, rsp_data,
           sram_chip_en, sram_wen, sram_ren, sram_waddr, sram_raddr, sram_din
  );

  modport master (
    output req_valid, req_wr, req_lock, req_addr, req_wdata, sram_dout,
    input  req_ready, rsp_valid, rsp_id, rsp_data,
           sram_chip_en, sram_wen, sram_ren, sram_waddr, sram_raddr, sram_din
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one registered-output SRAM among NREQ requesters,
// with an optional grant lock for back-to-back bursts and tagged 1-cycle read responses.
module sram_rr_arbiter #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDW        = 1
) (
  input  logic                clk,
  input  logic                rst,
  sram_rr_arbiter_if.slave    bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ARB, LOCK} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         lock_id;
  logic [PW-1:0]         lock_id_nxt;
  logic                  rsp_valid_q;
  logic [IDW-1:0]        rsp_id_q;

  logic [NREQ-1:0]       grant_vec;
  logic [PW-1:0]         grant_idx;
  logic                  found;
  int unsigned           cand;
  logic                  xfer;
  logic                  wr_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic                  rsp_vld;

  // Grant: in LOCK only the owner may proceed; in ARB search ptr+1 .. ptr.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    grant_vec = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    if (state == LOCK) begin
      if (bus.req_valid[lock_id]) begin
        grant_idx = lock_id;
        found     = 1'b1;
      end
    end else begin
      for (int off = 1; off <= NREQ; off++) begin
        cand = (int'(ptr) + off) % NREQ;
        if (!found && bus.req_valid[cand]) begin
          found     = 1'b1;
          grant_idx = PW'(cand);
        end
      end
    end
    if (found && !rst) grant_vec[grant_idx] = 1'b1;
  end

  assign xfer      = |grant_vec;
  assign wr_sel    = bus.req_wr[grant_idx];
  assign addr_sel  = bus.req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign wdata_sel = bus.req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  assign bus.req_ready = grant_vec;

  // SRAM pins are live only in the transfer cycle and quiet (all zero) otherwise.
  always_comb begin
    bus.sram_chip_en = xfer;
    bus.sram_wen     = xfer & wr_sel;
    bus.sram_ren     = xfer & ~wr_sel;
    bus.sram_waddr   = (xfer && wr_sel)  ? addr_sel  : '0;
    bus.sram_raddr   = (xfer && !wr_sel) ? addr_sel  : '0;
    bus.sram_din     = (xfer && wr_sel)  ? wdata_sel : '0;
  end

  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    case (state)
      ARB: begin
        if (xfer && bus.req_lock[grant_idx]) begin
          state_nxt   = LOCK;
          lock_id_nxt = grant_idx;
        end
      end
      LOCK: begin
        // Owner going idle for a cycle releases the lock just like an unlocked transfer.
        if (!bus.req_valid[lock_id] || (xfer && !bus.req_lock[lock_id])) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB;
      lock_id     <= '0;
      ptr         <= PW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_nxt;
      lock_id     <= lock_id_nxt;
      rsp_valid_q <= xfer & ~wr_sel;
      if (xfer) ptr <= grant_idx;
      if (xfer && !wr_sel) rsp_id_q <= IDW'(grant_idx);
    end
  end

  // Response registers are masked while rst is held so every output reads zero.
  assign rsp_vld       = rsp_valid_q & ~rst;
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_id    = rst ? '0 : rsp_id_q;
  assign bus.rsp_data  = rsp_vld ? bus.sram_dout : '0;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (owner/last-grant bookkeeping and a shadow memory).
module tb_sram_rr_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int IDW  = 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sram_rr_arbiter_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDW(IDW)) bus ();

  sram_rr_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment SRAM: registered read port, write visible from the next cycle.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] dout_r;
  assign bus.sram_dout = dout_r;

  always @(posedge clk) begin
    if (bus.sram_chip_en && bus.sram_wen) mem[bus.sram_waddr] <= bus.sram_din;
    if (bus.sram_chip_en && bus.sram_ren) dout_r <= mem[bus.sram_raddr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit wr, input bit lk,
                         input int a, input int d);
    bus.req_valid[i]          = v;
    bus.req_wr[i]             = wr;
    bus.req_lock[i]           = lk;
    bus.req_addr[i*AW +: AW]  = AW'(a);
    bus.req_wdata[i*DW +: DW] = DW'(d);
  endtask

  task automatic idle_all();
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    set_req(0, 1, 0, 0, 3, 0);
    set_req(1, 1, 1, 0, 5, 8'h77);
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.sram_chip_en, bus.sram_wen, bus.sram_ren} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b ce/wen/ren=%b%b%b, want all 0",
               bus.req_ready, bus.sram_chip_en, bus.sram_wen, bus.sram_ren);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got valid=%b id=%0d data=%h, want 0", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    next_cycle();
    idle_all();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(0, 1, 0, 0, 3, 0);
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.sram_chip_en, bus.sram_ren, bus.sram_wen, bus.sram_raddr} !== {2'b01, 3'b110, 4'd3}) begin
      n_fail++;
      $display("FAIL single_read_issue: got ready=%b ce=%b ren=%b wen=%b raddr=%0d, want 01 1 1 0 3",
               bus.req_ready, bus.sram_chip_en, bus.sram_ren, bus.sram_wen, bus.sram_raddr);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b0, 8'h5A}) begin
      n_fail++;
      $display("FAIL single_read_rsp: got valid=%b id=%0d data=%h, want 1 0 5a", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_alternate();
    logic [DW-1:0] want_data;
    do_reset();
    set_req(0, 1, 0, 0, 1, 0);
    set_req(1, 1, 0, 0, 2, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== NREQ'(1 << (c % 2))) begin
        n_fail++;
        $display("FAIL alternate_grant c=%0d: got %b, want %b", c, bus.req_ready, NREQ'(1 << (c % 2)));
      end
      if (c > 0) begin
        want_data = ((c - 1) % 2 == 0) ? 8'h11 : 8'h22;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, IDW'((c - 1) % 2), want_data}) begin
          n_fail++;
          $display("FAIL alternate_rsp c=%0d: got valid=%b id=%0d data=%h, want 1 %0d %h",
                   c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, (c - 1) % 2, want_data);
        end
      end
      next_cycle();
    end
    idle_all();
    next_cycle();
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(1, 1, 1, 0, 7, 8'hC3);
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.sram_wen, bus.sram_ren, bus.sram_waddr, bus.sram_din} !== {2'b10, 2'b10, 4'd7, 8'hC3}) begin
      n_fail++;
      $display("FAIL write_issue: got ready=%b wen=%b ren=%b waddr=%0d din=%h, want 10 1 0 7 c3",
               bus.req_ready, bus.sram_wen, bus.sram_ren, bus.sram_waddr, bus.sram_din);
    end
    next_cycle();
    set_req(1, 1, 0, 0, 7, 0);
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.sram_ren, bus.sram_raddr} !== {2'b10, 1'b1, 4'd7}) begin
      n_fail++;
      $display("FAIL write_read_issue: got ready=%b ren=%b raddr=%0d, want 10 1 7", bus.req_ready, bus.sram_ren, bus.sram_raddr);
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, 8'hC3}) begin
      n_fail++;
      $display("FAIL write_read_rsp: got valid=%b id=%0d data=%h, want 1 1 c3", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_lock_burst();
    do_reset();
    set_req(1, 1, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      set_req(0, 1, 1, (c < 3), 8 + c, 8'h40 + c);
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 2'b01) begin
        n_fail++;
        $display("FAIL lock_burst_hold c=%0d: got ready=%b, want 01", c, bus.req_ready);
      end
      next_cycle();
    end
    set_req(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_burst_release: got ready=%b, want 10", bus.req_ready);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_lock_drop();
    do_reset();
    set_req(0, 1, 1, 1, 9, 8'h99);
    set_req(1, 1, 0, 0, 1, 0);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL lock_drop_take: got ready=%b, want 01", bus.req_ready);
    end
    next_cycle();
    set_req(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL lock_drop_idle: got ready=%b, want 00", bus.req_ready);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL lock_drop_next: got ready=%b, want 10", bus.req_ready);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    set_req(1, 1, 0, 1, 4, 0);
    next_cycle();
    set_req(0, 1, 0, 0, 3, 0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_ready: got ready=%b, want 00", bus.req_ready);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_mid_after: got rsp_valid=%b ready=%b, want 0 01", bus.rsp_valid, bus.req_ready);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {2'b10, 1'b1, 1'b0, 8'h5A}) begin
      n_fail++;
      $display("FAIL rst_mid_second: got ready=%b rsp=%b id=%0d data=%h, want 10 1 0 5a",
               bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    next_cycle();
    idle_all();
    next_cycle();
  endtask

  task automatic test_random();
    logic [DW-1:0]   ref_mem [2**AW];
    int              last;
    int              owner;
    bit              pend_v;
    int              pend_id;
    logic [DW-1:0]   pend_d;
    int              g;
    logic [NREQ-1:0] exp_ready;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    bit              w;
    logic [2+3+AW+AW+DW-1:0] exp_drive;
    logic [2+3+AW+AW+DW-1:0] got_drive;

    do_reset();
    ref_mem = mem;
    last    = NREQ - 1;
    owner   = -1;
    pend_v  = 1'b0;
    pend_id = 0;
    pend_d  = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1, $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 2**AW - 1), $urandom_range(0, 255));

      // Expected grant straight from the rules: owner only while locked, else rotate from last.
      g = -1;
      if (!rst) begin
        if (owner >= 0) begin
          if (bus.req_valid[owner]) g = owner;
        end else begin
          for (int k = 1; k <= NREQ && g < 0; k++)
            if (bus.req_valid[(last + k) % NREQ]) g = (last + k) % NREQ;
        end
      end
      exp_ready = '0;
      a = '0;
      d = '0;
      w = 1'b0;
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        a = bus.req_addr[g*AW +: AW];
        d = bus.req_wdata[g*DW +: DW];
        w = bus.req_wr[g];
      end
      exp_drive = {exp_ready, (g >= 0), (g >= 0) && w, (g >= 0) && !w,
                   (g >= 0 && w) ? a : AW'(0), (g >= 0 && !w) ? a : AW'(0), (g >= 0 && w) ? d : DW'(0)};

      @(negedge clk);
      got_drive = {bus.req_ready, bus.sram_chip_en, bus.sram_wen, bus.sram_ren,
                   bus.sram_waddr, bus.sram_raddr, bus.sram_din};
      n_checks++;
      if (got_drive !== exp_drive) begin
        n_fail++;
        $display("FAIL rand_drive cyc=%0d: got %h, want %h (ready,ce,wen,ren,waddr,raddr,din)", cyc, got_drive, exp_drive);
      end
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_data} !== {pend_v && !rst, (pend_v && !rst) ? pend_d : DW'(0)}) begin
        n_fail++;
        $display("FAIL rand_rsp cyc=%0d: got valid=%b data=%h, want %b %h",
                 cyc, bus.rsp_valid, bus.rsp_data, pend_v && !rst, pend_d);
      end
      if (pend_v && !rst) begin
        n_checks++;
        if (bus.rsp_id !== IDW'(pend_id)) begin
          n_fail++;
          $display("FAIL rand_rsp_id cyc=%0d: got %0d, want %0d", cyc, bus.rsp_id, pend_id);
        end
      end

      @(posedge clk);
      if (rst) begin
        last   = NREQ - 1;
        owner  = -1;
        pend_v = 1'b0;
      end else begin
        pend_v = 1'b0;
        if (owner >= 0) begin
          if (!bus.req_valid[owner] || !bus.req_lock[owner]) owner = -1;
        end else if (g >= 0 && bus.req_lock[g]) begin
          owner = g;
        end
        if (g >= 0) begin
          last = g;
          if (w) ref_mem[a] = d;
          else begin
            pend_v  = 1'b1;
            pend_id = g;
            pend_d  = ref_mem[a];
          end
        end
      end
      #1;
      if (g >= 0) set_req(g, 0, 0, 0, 0, 0);
    end
    rst = 1'b0;
    idle_all();
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    dout_r        = '0;
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i * 37 + 5);
    mem[1] = 8'h11;
    mem[2] = 8'h22;
    mem[3] = 8'h5A;

    test_reset();
    test_single_read();
    test_alternate();
    test_write_read();
    test_lock_burst();
    test_lock_drop();
    test_reset_mid_read();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
